// File: rtl/lcd_msg_arbiter_if.sv
// Client write/commit ports and the LCD character port of the two-client
// message arbiter, bundled so the arbiter and its environment share one bus.
interface lcd_msg_arbiter_if;
  logic       WE_A;
  logic       WE_B;
  logic [4:0] WADDR_A;
  logic [4:0] WADDR_B;
  logic [7:0] WDATA_A;
  logic [7:0] WDATA_B;
  logic [5:0] LEN_A;
  logic [5:0] LEN_B;
  logic       COMMIT_A;
  logic       COMMIT_B;
  logic       BUSY_A;
  logic       BUSY_B;
  logic       DONE_A;
  logic       DONE_B;
  logic       LCD_READY;
  logic       LCD_SHOW;
  logic [7:0] LCD_DATA;
  logic       LCD_MARK1;
  logic       LCD_MARK2;
  logic [1:0] GRANT;

  // Arbiter side
  modport slave (
    input  WE_A, WE_B, WADDR_A, WADDR_B, WDATA_A, WDATA_B,
    input  LEN_A, LEN_B, COMMIT_A, COMMIT_B, LCD_READY,
    output BUSY_A, BUSY_B, DONE_A, DONE_B,
    output LCD_SHOW, LCD_DATA, LCD_MARK1, LCD_MARK2, GRANT
  );

  // Client / LCD side
  modport master (
    output WE_A, WE_B, WADDR_A, WADDR_B, WDATA_A, WDATA_B,
    output LEN_A, LEN_B, COMMIT_A, COMMIT_B, LCD_READY,
    input  BUSY_A, BUSY_B, DONE_A, DONE_B,
    input  LCD_SHOW, LCD_DATA, LCD_MARK1, LCD_MARK2, GRANT
  );
endinterface

// File: rtl/lcd_msg_arbiter.sv
// Two-client LCD message arbiter: each client fills its own character buffer,
// commits a length, and the arbiter streams the characters to the LCD block
// one at a time with a SHOW/READY handshake, round-robin between clients.
module lcd_msg_arbiter #(
  parameter int MAX_LEN = 32,
  parameter int GUARD   = 4
) (
  input logic              CLK_27,
  input logic              RESET_N,
  lcd_msg_arbiter_if.slave bus
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [5:0] MAX_LEN_V = 6'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_ACK, S_WAIT, S_GUARD_WAIT, S_FINAL_WAIT
  } state_t;

  logic [7:0] buf_a [MAX_LEN];
  logic [7:0] buf_b [MAX_LEN];

  state_t        state_q, state_d;
  logic          busy_a_q, busy_a_d, busy_b_q, busy_b_d;
  logic [5:0]    len_a_q, len_a_d, len_b_q, len_b_d;
  logic          prio_b_q, prio_b_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [1:0]    grant_q, grant_d;
  logic          show_q, show_d;
  logic [7:0]    data_q, data_d;
  logic          mark1_q, mark1_d, mark2_q, mark2_d;
  logic          done_a_q, done_a_d, done_b_q, done_b_d;

  logic          pick_b, rd_sel_b;
  logic [IW-1:0] rd_idx;
  logic [7:0]    rd_byte;
  logic [5:0]    rd_len, own_len;
  logic [1:0]    rd_marks;

  // {mark1, mark2}: end-of-message wins over the line-change at index 15
  function automatic logic [1:0] char_marks(input logic [IW-1:0] idx, input logic [5:0] len);
    logic last;
    last = (6'(idx) == len - 6'd1);
    return {(6'(idx) == 6'd15) && !last, last};
  endfunction

  // Client buffers: writes accepted only while that client is not busy
  always_ff @(posedge CLK_27) begin
    if (bus.WE_A && !busy_a_q) buf_a[bus.WADDR_A[IW-1:0]] <= bus.WDATA_A;
    if (bus.WE_B && !busy_b_q) buf_b[bus.WADDR_B[IW-1:0]] <= bus.WDATA_B;
  end

  // Lookahead read of the next character to present (first char on grant, else index+1)
  always_comb begin
    pick_b   = busy_b_q && (!busy_a_q || prio_b_q);
    rd_sel_b = grant_q[1];
    rd_idx   = idx_q + 1'b1;
    if (state_q == S_IDLE) begin
      rd_sel_b = pick_b;
      rd_idx   = '0;
    end
    rd_byte  = rd_sel_b ? buf_b[rd_idx] : buf_a[rd_idx];
    rd_len   = rd_sel_b ? len_b_q : len_a_q;
    own_len  = grant_q[1] ? len_b_q : len_a_q;
    rd_marks = char_marks(rd_idx, rd_len);
  end

  // Next-state logic: commit acceptance plus the character transfer FSM
  always_comb begin
    state_d  = state_q;
    busy_a_d = busy_a_q;
    busy_b_d = busy_b_q;
    len_a_d  = len_a_q;
    len_b_d  = len_b_q;
    prio_b_d = prio_b_q;
    idx_d    = idx_q;
    gcnt_d   = gcnt_q;
    grant_d  = grant_q;
    show_d   = show_q;
    data_d   = data_q;
    mark1_d  = mark1_q;
    mark2_d  = mark2_q;
    done_a_d = 1'b0;
    done_b_d = 1'b0;

    // A commit from the client not currently being served is simply queued
    if (bus.COMMIT_A && !busy_a_q && bus.LEN_A != 6'd0 && bus.LEN_A <= MAX_LEN_V) begin
      busy_a_d = 1'b1;
      len_a_d  = bus.LEN_A;
    end
    if (bus.COMMIT_B && !busy_b_q && bus.LEN_B != 6'd0 && bus.LEN_B <= MAX_LEN_V) begin
      busy_b_d = 1'b1;
      len_b_d  = bus.LEN_B;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.LCD_READY && (busy_a_q || busy_b_q)) begin
          grant_d  = pick_b ? 2'b10 : 2'b01;
          prio_b_d = !pick_b;
          idx_d    = '0;
          show_d   = 1'b1;
          data_d   = rd_byte;
          {mark1_d, mark2_d} = rd_marks;
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        if (!bus.LCD_READY) begin
          show_d  = 1'b0;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (6'(idx_q) == own_len - 6'd1) begin
          gcnt_d  = '0;
          state_d = S_GUARD_WAIT;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.LCD_READY) begin
          idx_d   = rd_idx;
          show_d  = 1'b1;
          data_d  = rd_byte;
          {mark1_d, mark2_d} = rd_marks;
          state_d = S_SEND;
        end
      end
      S_GUARD_WAIT: begin
        if (gcnt_q == GW'(GUARD - 1)) state_d = S_FINAL_WAIT;
        else                          gcnt_d  = gcnt_q + 1'b1;
      end
      S_FINAL_WAIT: begin
        if (bus.LCD_READY) begin
          done_a_d = grant_q[0];
          done_b_d = grant_q[1];
          if (grant_q[0]) busy_a_d = 1'b0;
          if (grant_q[1]) busy_b_d = 1'b0;
          grant_d  = 2'b00;
          data_d   = 8'h00;
          mark1_d  = 1'b0;
          mark2_d  = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers; reset aborts any transfer without DONE
  always_ff @(posedge CLK_27 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      busy_a_q <= 1'b0;
      busy_b_q <= 1'b0;
      prio_b_q <= 1'b0;
      idx_q    <= '0;
      gcnt_q   <= '0;
      grant_q  <= 2'b00;
      show_q   <= 1'b0;
      data_q   <= 8'h00;
      mark1_q  <= 1'b0;
      mark2_q  <= 1'b0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_a_q <= busy_a_d;
      busy_b_q <= busy_b_d;
      prio_b_q <= prio_b_d;
      idx_q    <= idx_d;
      gcnt_q   <= gcnt_d;
      grant_q  <= grant_d;
      show_q   <= show_d;
      data_q   <= data_d;
      mark1_q  <= mark1_d;
      mark2_q  <= mark2_d;
      done_a_q <= done_a_d;
      done_b_q <= done_b_d;
    end
  end

  // Latched lengths are only consulted while the matching busy flag is set
  always_ff @(posedge CLK_27) begin
    len_a_q <= len_a_d;
    len_b_q <= len_b_d;
  end

  assign bus.BUSY_A    = busy_a_q;
  assign bus.BUSY_B    = busy_b_q;
  assign bus.DONE_A    = done_a_q;
  assign bus.DONE_B    = done_b_q;
  assign bus.LCD_SHOW  = show_q;
  assign bus.LCD_DATA  = data_q;
  assign bus.LCD_MARK1 = mark1_q;
  assign bus.LCD_MARK2 = mark2_q;
  assign bus.GRANT     = grant_q;

endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// Scoreboard bench for lcd_msg_arbiter: stimulus pushes expected characters
// and DONE owners; a monitor pops them as the DUT presents characters/DONEs.
module tb_lcd_msg_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lcd_msg_arbiter_if bus();

  lcd_msg_arbiter #(.MAX_LEN(32), .GUARD(4)) dut (
    .CLK_27 (clk),
    .RESET_N(rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       m1;
    logic       m2;
    logic [1:0] grant;
  } exp_t;

  exp_t       exp_q[$];
  int         done_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] msg_a [32];
  logic [7:0] msg_b [32];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  // Monitor: characters on rising SHOW, DONE pulses, and output stability
  initial begin : monitor
    exp_t       e;
    int         got;
    int         want;
    logic       prev_show = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_m1 = 1'b0;
    logic       prev_m2 = 1'b0;
    logic [1:0] prev_grant = 2'b00;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (bus.LCD_SHOW && !prev_show) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_char got data=%h grant=%b", bus.LCD_DATA, bus.GRANT);
          end else begin
            e = exp_q.pop_front();
            if (bus.LCD_DATA !== e.data || bus.LCD_MARK1 !== e.m1 ||
                bus.LCD_MARK2 !== e.m2 || bus.GRANT !== e.grant) begin
              errors++;
              $display("FAIL char got data=%h m1=%b m2=%b grant=%b expected data=%h m1=%b m2=%b grant=%b",
                       bus.LCD_DATA, bus.LCD_MARK1, bus.LCD_MARK2, bus.GRANT,
                       e.data, e.m1, e.m2, e.grant);
            end
          end
        end else if (bus.GRANT != 2'b00 && prev_grant != 2'b00) begin
          checks++;
          if (bus.LCD_DATA !== prev_data || bus.LCD_MARK1 !== prev_m1 || bus.LCD_MARK2 !== prev_m2) begin
            errors++;
            $display("FAIL stable got data=%h m1=%b m2=%b expected data=%h m1=%b m2=%b",
                     bus.LCD_DATA, bus.LCD_MARK1, bus.LCD_MARK2, prev_data, prev_m1, prev_m2);
          end
        end
        if (bus.DONE_A === 1'b1 || bus.DONE_B === 1'b1) begin
          checks++;
          got = (bus.DONE_A && bus.DONE_B) ? 2 : (bus.DONE_B ? 1 : 0);
          if (done_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done got client=%0d", got);
          end else begin
            want = done_q.pop_front();
            if (got != want) begin
              errors++;
              $display("FAIL done_owner got=%0d expected=%0d", got, want);
            end
          end
        end
      end
      prev_show  = bus.LCD_SHOW;
      prev_data  = bus.LCD_DATA;
      prev_m1    = bus.LCD_MARK1;
      prev_m2    = bus.LCD_MARK2;
      prev_grant = bus.GRANT;
    end
  end

  // LCD model: drops READY for two cycles after each character it sees
  initial begin : lcd_model
    bus.LCD_READY = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.LCD_SHOW === 1'b1 && bus.LCD_READY) begin
        bus.LCD_READY = 1'b0;
        repeat (2) @(negedge clk);
        bus.LCD_READY = 1'b1;
      end
    end
  end

  task automatic wr(input int c, input int addr, input logic [7:0] d);
    @(negedge clk);
    if (c == 0) begin
      bus.WE_A = 1'b1; bus.WADDR_A = 5'(addr); bus.WDATA_A = d;
    end else begin
      bus.WE_B = 1'b1; bus.WADDR_B = 5'(addr); bus.WDATA_B = d;
    end
    @(negedge clk);
    bus.WE_A = 1'b0;
    bus.WE_B = 1'b0;
  endtask

  task automatic load(input int c, input int addr, input logic [7:0] d);
    if (c == 0) msg_a[addr] = d;
    else        msg_b[addr] = d;
    wr(c, addr, d);
  endtask

  task automatic commit(input bit a, input bit b, input int la, input int lb);
    @(negedge clk);
    bus.COMMIT_A = a; bus.LEN_A = 6'(la);
    bus.COMMIT_B = b; bus.LEN_B = 6'(lb);
    @(negedge clk);
    bus.COMMIT_A = 1'b0;
    bus.COMMIT_B = 1'b0;
  endtask

  task automatic push_msg(input int c, input int len, input int upto);
    exp_t e;
    for (int i = 0; i < upto; i++) begin
      e.data  = (c == 0) ? msg_a[i] : msg_b[i];
      e.m2    = (i == len - 1);
      e.m1    = (i == 15) && !e.m2;
      e.grant = (c == 0) ? 2'b01 : 2'b10;
      exp_q.push_back(e);
    end
    if (upto == len) done_q.push_back(c);
  endtask

  task automatic push_char(input logic [7:0] d, input logic m2);
    exp_t e;
    e.data = d; e.m1 = 1'b0; e.m2 = m2; e.grant = 2'b01;
    exp_q.push_back(e);
  endtask

  task automatic wait_quiet(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0 || bus.GRANT != 2'b00) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got pending_chars=%0d pending_dones=%0d expected 0", name, exp_q.size(), done_q.size());
      exp_q.delete();
      done_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    rst_n = 1'b0;
    bus.WE_A = 1'b0; bus.WE_B = 1'b0;
    bus.WADDR_A = '0; bus.WADDR_B = '0;
    bus.WDATA_A = '0; bus.WDATA_B = '0;
    bus.LEN_A = '0; bus.LEN_B = '0;
    bus.COMMIT_A = 1'b0; bus.COMMIT_B = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", bus.GRANT, 0);
    chk("rst_show", bus.LCD_SHOW, 0);
    chk("rst_data", bus.LCD_DATA, 0);
    chk("rst_marks", {bus.LCD_MARK1, bus.LCD_MARK2}, 0);
    chk("rst_busy", {bus.BUSY_A, bus.BUSY_B}, 0);
    chk("rst_done", {bus.DONE_A, bus.DONE_B}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // "HELLO" on A with hand-written expectations
    load(0, 0, 8'h48); load(0, 1, 8'h45); load(0, 2, 8'h4C); load(0, 3, 8'h4C); load(0, 4, 8'h4F);
    push_char(8'h48, 1'b0); push_char(8'h45, 1'b0); push_char(8'h4C, 1'b0);
    push_char(8'h4C, 1'b0); push_char(8'h4F, 1'b1);
    done_q.push_back(0);
    commit(1, 0, 5, 0);
    chk("hello_busy_a", bus.BUSY_A, 1);
    wait_quiet("hello");
    chk("hello_busy_a_after", bus.BUSY_A, 0);

    // 20 characters: line change at 15, end at 19, 0x0A passed through
    for (int i = 0; i < 20; i++) load(0, i, (i == 2) ? 8'h0A : 8'(8'h40 + i));
    push_msg(0, 20, 20);
    commit(1, 0, 20, 0);
    wait_quiet("len20");

    // 16 characters: end-of-message suppresses the line change
    push_msg(0, 16, 16);
    commit(1, 0, 16, 0);
    wait_quiet("len16");

    // Out-of-range lengths are ignored
    commit(1, 0, 0, 0);
    chk("len0_busy_a", bus.BUSY_A, 0);
    commit(1, 0, 33, 0);
    chk("len33_busy_a", bus.BUSY_A, 0);

    // Writes during BUSY do not disturb the buffer
    load(0, 0, 8'h61); load(0, 1, 8'h62); load(0, 2, 8'h63);
    push_msg(0, 3, 3);
    commit(1, 0, 3, 0);
    chk("abc_busy_a", bus.BUSY_A, 1);
    wr(0, 1, 8'h5A);
    wait_quiet("busy_write");

    // A served last: simultaneous commits go to B first
    load(0, 0, 8'h70); load(0, 1, 8'h71);
    load(1, 0, 8'h78); load(1, 1, 8'h79); load(1, 2, 8'h7A);
    push_msg(1, 3, 3);
    push_msg(0, 2, 2);
    commit(1, 1, 2, 3);
    wait_quiet("rr_b_first");

    // Reset while index 3 of a 10-character message is on the bus
    for (int i = 0; i < 10; i++) load(0, i, 8'(8'h20 + i));
    push_msg(0, 10, 4);
    commit(1, 0, 10, 0);
    n = 0;
    while (!(exp_q.size() == 0 && bus.LCD_SHOW === 1'b1) && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("abort_reached_idx3", (n < 2000), 1);
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    chk("abort_show", bus.LCD_SHOW, 0);
    chk("abort_grant", bus.GRANT, 0);
    chk("abort_busy_a", bus.BUSY_A, 0);
    chk("abort_data", bus.LCD_DATA, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_busy_a_after", bus.BUSY_A, 0);
    chk("abort_grant_after", bus.GRANT, 0);

    // After reset A has priority on simultaneous commits
    load(0, 0, 8'h31); load(0, 1, 8'h32);
    load(1, 0, 8'h37); load(1, 1, 8'h38); load(1, 2, 8'h39);
    push_msg(0, 2, 2);
    push_msg(1, 3, 3);
    commit(1, 1, 2, 3);
    chk("rr_busy_both", {bus.BUSY_A, bus.BUSY_B}, 2'b11);
    wait_quiet("rr_a_first");
    chk("final_busy", {bus.BUSY_A, bus.BUSY_B}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_msg_arbiter.md
LCD_MSG_ARBITER -- requirements
Module: lcd_msg_arbiter

Interface
REQ-001 Parameter MAX_LEN, default 32, maximum message length in characters (two 16-char lines).
REQ-002 Parameter GUARD, default 4, cycles to wait after the last character before polling LCD_READY.
REQ-003 CLK_27  in  1  system clock; all state changes on its rising edge.
REQ-004 RESET_N  in  1  asynchronous, active-low reset.
REQ-005 WE_A / WE_B  in  1  client buffer write strobe.
REQ-006 WADDR_A / WADDR_B  in  5  client buffer write address.
REQ-007 WDATA_A / WDATA_B  in  8  client character byte.
REQ-008 LEN_A / LEN_B  in  6  message length, sampled on COMMIT.
REQ-009 COMMIT_A / COMMIT_B  in  1  one-cycle request to display the buffered message.
REQ-010 BUSY_A / BUSY_B  out  1  high from accepted COMMIT until DONE.
REQ-011 DONE_A / DONE_B  out  1  one-cycle pulse when the message is fully sent.
REQ-012 LCD_READY  in  1  LCD block ready flag (its LCDfinish).
REQ-013 LCD_SHOW  out  1  character-valid strobe to the LCD block.
REQ-014 LCD_DATA  out  8  character byte to the LCD block.
REQ-015 LCD_MARK1  out  1  line-change flag, valid with LCD_DATA.
REQ-016 LCD_MARK2  out  1  end-of-message flag, valid with LCD_DATA.
REQ-017 GRANT  out  2  one-hot owner (bit0=A, bit1=B); 00 when idle.

Function
REQ-018 Each client SHALL own a MAX_LEN x 8 buffer; writes with WE high and BUSY low SHALL store WDATA at WADDR; writes while BUSY SHALL be ignored.
REQ-019 COMMIT with BUSY low and 1 <= LEN <= MAX_LEN SHALL latch LEN, set pending and raise BUSY next cycle; other COMMITs SHALL be ignored.
REQ-020 FSM states: IDLE, SEND, ACK, WAIT, GUARD_WAIT, FINAL_WAIT.
REQ-021 IDLE: when LCD_READY is high and any client pending, grant one, index:=0, go to SEND; GRANT valid from the next cycle.
REQ-022 Arbitration SHALL be round-robin: with both pending, grant the client not served last; after reset A has priority.
REQ-023 SEND: LCD_SHOW=1, LCD_DATA=buffer[index]; stay until LCD_READY=0, then go to ACK.
REQ-024 ACK: LCD_SHOW=0; go to GUARD_WAIT if index==LEN-1, else WAIT.
REQ-025 LCD_DATA, LCD_MARK1, LCD_MARK2 SHALL stay stable from SEND entry until leaving WAIT / FINAL_WAIT.
REQ-026 LCD_MARK1 SHALL be 1 only when index==15 and index!=LEN-1.
REQ-027 LCD_MARK2 SHALL be 1 only when index==LEN-1; MARK2 takes precedence over MARK1 (LEN=16 gives MARK1=0).
REQ-028 WAIT: on LCD_READY=1, index:=index+1, go to SEND (next character).
REQ-029 GUARD_WAIT: count GUARD cycles, then FINAL_WAIT; LCD_READY ignored during count.
REQ-030 FINAL_WAIT: on LCD_READY=1, pulse DONE of the owner, clear its pending and BUSY, GRANT:=00, go to IDLE.
REQ-031 Byte 0x0A SHALL be passed through unchanged (LCD block treats it as skip).
REQ-032 COMMIT from the non-owning client during a transfer SHALL be accepted and queued.
REQ-033 Back-to-back: a pending client SHALL be granted no earlier than the cycle after DONE.

Reset
REQ-034 RESET_N low SHALL immediately force IDLE, all outputs 0, pending flags clear, index 0, round-robin pointer to A.
REQ-035 Reset mid-transfer SHALL abort without DONE; buffer contents need not be cleared.

Verification
REQ-036 Write "HELLO" to A, COMMIT_A LEN=5, LCD model ready -> five SEND/ACK cycles bytes 48 45 4C 4C 4F, MARK2 only on 4F, DONE_A one pulse, BUSY_A low after.
REQ-037 A LEN=20 -> MARK1=1 only on character index 15, MARK2 only on index 19.
REQ-038 A LEN=16 -> MARK1 never asserted, MARK2 on index 15.
REQ-039 COMMIT_A and COMMIT_B same cycle -> A served first, then B; repeat -> B first next round only if A served last.
REQ-040 COMMIT_A LEN=0 and LEN=33 -> ignored, BUSY_A stays 0; WE_A during BUSY_A -> buffer unchanged.
REQ-041 RESET_N low during index 3 of LEN=10 -> LCD_SHOW, GRANT, BUSY_A 0 immediately, no DONE_A.
